// File: rtl/mc_main_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute and drives datapath controls.
// Optional macro MC_JUMP_EN enables the j instruction (opcode 000010) through the JUMP state.
module mc_main_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       Opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic [1:0]       PCSource,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             ZeroExt,
  output logic [2:0]       ALUOp,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  state_t           w_next;
  logic             w_retire;

  always_comb begin
    w_next   = S_FETCH;
    w_retire = 1'b0;
    case (r_state)
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW:              w_next = S_MEMADR;
          OP_RTYPE:                  w_next = S_EXEC;
          OP_BEQ:                    w_next = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI:  w_next = S_IEXEC;
`ifdef MC_JUMP_EN
          OP_J:                      w_next = S_JUMP;
`endif
          default:                   w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (Opcode == OP_SW)      w_next = S_MEMWR;
        else if (Opcode == OP_LW) w_next = S_MEMRD;
        else                      w_next = S_FETCH;
      end
      S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  w_retire = 1'b1;
      S_MEMWR: begin
        w_next   = mem_ready ? S_FETCH : S_MEMWR;
        w_retire = mem_ready;
      end
      S_EXEC:   w_next = S_RWB;
      S_RWB:    w_retire = 1'b1;
      S_BRANCH: w_retire = 1'b1;
`ifdef MC_JUMP_EN
      S_JUMP:   w_retire = 1'b1;
`endif
      S_IEXEC:  w_next = S_IWB;
      S_IWB:    w_retire = 1'b1;
      default:  w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_count <= r_count + CNT_W'(1);
    end
  end

  // Moore decode of the current state; rst forces every output low in the same cycle.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 2'b00;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ZeroExt     = 1'b0;
    ALUOp       = 3'b000;
    illegal_op  = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          ALUOp   = 3'b010;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: begin
          ALUSrcB    = 2'b11;
          ALUOp      = 3'b010;
          illegal_op = (w_next == S_FETCH);
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUOp   = 3'b010;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 3'b100;
        end
        S_RWB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 3'b011;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
`ifdef MC_JUMP_EN
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
`endif
        S_IEXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          case (Opcode)
            OP_ANDI: begin ALUOp = 3'b000; ZeroExt = 1'b1; end
            OP_ORI:  begin ALUOp = 3'b001; ZeroExt = 1'b1; end
            default: ALUOp = 3'b010;
          endcase
        end
        S_IWB:   RegWrite = 1'b1;
        default: ;
      endcase
    end
  end

  assign state       = rst ? 4'd0 : r_state;
  assign instr_count = rst ? '0 : r_count;

endmodule

// File: tb/tb_mc_main_control.sv
// Scoreboard bench for mc_main_control (CNT_W=4 build so the retire counter wrap is reachable).
module tb_mc_main_control;
  localparam int CNT_W = 4;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_ADDI= 6'b001000;
  localparam logic [5:0] OP_ANDI= 6'b001100;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] Opcode = 6'd0;
  logic mem_ready = 1'b1;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic MemtoReg, RegDst, RegWrite, ALUSrcA, ZeroExt, illegal_op;
  logic [1:0] PCSource, ALUSrcB;
  logic [2:0] ALUOp;
  logic [3:0] state;
  logic [CNT_W-1:0] instr_count;

  mc_main_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .Opcode(Opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ZeroExt(ZeroExt), .ALUOp(ALUOp),
    .illegal_op(illegal_op), .state(state), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  logic [18:0] w_ctrl;
  assign w_ctrl = {PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
                   MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ZeroExt, ALUOp, illegal_op};

  typedef struct {
    string            tag;
    logic [3:0]       st;
    logic [18:0]      ctrl;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic legal_op(input logic [5:0] op);
    case (op)
      OP_R, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW: return 1'b1;
`ifdef MC_JUMP_EN
      OP_J: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Reference control word per state, written from the state table.
  function automatic logic [18:0] ctrl_of(input logic [3:0] st, input logic mr, input logic [5:0] op);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, zx, ill;
    logic [1:0] pcs, asb;
    logic [2:0] aop;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, zx, ill} = '0;
    pcs = 2'b00; asb = 2'b00; aop = 3'b000;
    case (st)
      4'd0:  begin mrd = 1; asb = 2'b01; aop = 3'b010; irw = mr; pcw = mr; end
      4'd1:  begin asb = 2'b11; aop = 3'b010; ill = !legal_op(op); end
      4'd2:  begin asa = 1; asb = 2'b10; aop = 3'b010; end
      4'd3:  begin mrd = 1; iord = 1; end
      4'd4:  begin m2r = 1; rw = 1; end
      4'd5:  begin mwr = 1; iord = 1; end
      4'd6:  begin asa = 1; aop = 3'b100; end
      4'd7:  begin rdst = 1; rw = 1; end
      4'd8:  begin asa = 1; aop = 3'b011; pcwc = 1; pcs = 2'b01; end
      4'd9:  begin pcw = 1; pcs = 2'b10; end
      4'd10: begin
        asa = 1; asb = 2'b10;
        aop = (op == OP_ANDI) ? 3'b000 : (op == OP_ORI) ? 3'b001 : 3'b010;
        zx  = (op == OP_ANDI) || (op == OP_ORI);
      end
      4'd11: rw = 1;
      default: ;
    endcase
    return {pcw, pcwc, pcs, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, zx, aop, ill};
  endfunction

  // Called #1 after a rising edge: drive inputs, queue expectation, compare at the falling edge.
  task automatic step(input string tag, input logic [3:0] st, input logic mr, input logic r);
    exp_t e, got;
    rst = r;
    mem_ready = mr;
    e.tag  = tag;
    e.st   = r ? 4'd0 : st;
    e.ctrl = r ? 19'd0 : ctrl_of(st, mr, Opcode);
    e.cnt  = r ? '0 : exp_cnt;
    sb_q.push_back(e);
    @(negedge clk);
    got = sb_q.pop_front();
    chk({got.tag, "_state"}, 32'(state), 32'(got.st));
    chk({got.tag, "_ctrl"}, 32'(w_ctrl), 32'(got.ctrl));
    chk({got.tag, "_cnt"}, 32'(instr_count), 32'(got.cnt));
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input int waits, input string tag);
    Opcode = op;
    step({tag, "_fetch"}, 4'd0, 1'b1, 1'b0);
    step({tag, "_decode"}, 4'd1, 1'b1, 1'b0);
    case (op)
      OP_LW: begin
        step({tag, "_memadr"}, 4'd2, 1'b1, 1'b0);
        repeat (waits) step({tag, "_memrd_wait"}, 4'd3, 1'b0, 1'b0);
        step({tag, "_memrd"}, 4'd3, 1'b1, 1'b0);
        step({tag, "_memwb"}, 4'd4, 1'b1, 1'b0);
      end
      OP_SW: begin
        step({tag, "_memadr"}, 4'd2, 1'b1, 1'b0);
        repeat (waits) step({tag, "_memwr_wait"}, 4'd5, 1'b0, 1'b0);
        step({tag, "_memwr"}, 4'd5, 1'b1, 1'b0);
      end
      OP_R: begin
        step({tag, "_exec"}, 4'd6, 1'b1, 1'b0);
        step({tag, "_rwb"}, 4'd7, 1'b1, 1'b0);
      end
      OP_BEQ: step({tag, "_branch"}, 4'd8, 1'b1, 1'b0);
      OP_ADDI, OP_ANDI, OP_ORI: begin
        step({tag, "_iexec"}, 4'd10, 1'b1, 1'b0);
        step({tag, "_iwb"}, 4'd11, 1'b1, 1'b0);
      end
`ifdef MC_JUMP_EN
      OP_J: step({tag, "_jump"}, 4'd9, 1'b1, 1'b0);
`endif
      default: ;
    endcase
    if (legal_op(op)) exp_cnt = exp_cnt + 1'b1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    step("rst0", 4'd0, 1'b1, 1'b1);
    step("rst1", 4'd0, 1'b1, 1'b1);
    Opcode = OP_R;
    step("fetch_stall", 4'd0, 1'b0, 1'b0);
    run_instr(OP_R, 0, "rtype");
    run_instr(OP_LW, 3, "lw");
    run_instr(OP_SW, 1, "sw");
    run_instr(OP_ORI, 0, "ori");
    run_instr(OP_ANDI, 0, "andi");
    run_instr(OP_ADDI, 0, "addi");
    run_instr(OP_BEQ, 0, "beq");
    run_instr(6'b111111, 0, "illegal");
    run_instr(OP_J, 0, "jump");
    while (exp_cnt != {CNT_W{1'b1}}) run_instr(OP_R, 0, "fill");
    run_instr(OP_R, 0, "wrap");
    Opcode = OP_R;
    step("after_wrap", 4'd0, 1'b0, 1'b0);
    chk("wrap_zero", 32'(instr_count), 32'd0);
    Opcode = OP_SW;
    step("rsw_fetch", 4'd0, 1'b1, 1'b0);
    step("rsw_decode", 4'd1, 1'b1, 1'b0);
    step("rsw_memadr", 4'd2, 1'b1, 1'b0);
    step("rsw_wait", 4'd5, 1'b0, 1'b0);
    step("rsw_rst", 4'd5, 1'b0, 1'b1);
    exp_cnt = '0;
    step("rsw_after", 4'd0, 1'b1, 1'b0);
    if (sb_q.size() != 0) chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mc_main_control.md
Name: mc_main_control

Overview:
- Multicycle MIPS main control FSM; sits directly upstream of the ALU control unit.
- Decodes IR opcode over several cycles. Drives datapath enables/selects and the 3-bit ALUOp that the ALU control unit consumes together with funct.
- Supports add, sub, and, or, slt, addi, andi, ori, lw, sw, beq. Memory accesses wait on a ready handshake.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- Opcode  in  6  IR[31:26]; stable from DECODE until return to FETCH
- mem_ready  in  1  memory completes access this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU Zero
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
- IorD  out  1  0 PC address, 1 ALUOut address
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR load
- MemtoReg  out  1  register write data select (1 = MDR)
- RegDst  out  1  1 = rd, 0 = rt
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0 PC, 1 A register
- ALUSrcB  out  2  00 B, 01 const 4, 10 sign/zero-ext imm, 11 ext imm << 2
- ZeroExt  out  1  1 = zero-extend immediate (andi/ori)
- ALUOp  out  3  010 add, 011 sub, 000 and, 001 or, 100 use funct
- illegal_op  out  1  one-cycle pulse on unsupported opcode
- state  out  4  current state encoding (debug)
- instr_count  out  CNT_W  retired instruction count

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-high (rst).
- While rst=1: every output is 0, including state and instr_count. Next state is FETCH (0).
- Outputs: Moore-decoded from state. Only IRWrite, PCWrite and state exit are qualified by mem_ready where noted. Every signal not listed for a state is 0.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11. Encodings 12–15 go to FETCH next cycle with all outputs 0.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=010, PCSource=00.
  - IRWrite=PCWrite=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=010. Next state by Opcode:
  - 100011 (lw) / 101011 (sw) → MEMADR
  - 000000 → EXEC
  - 000100 → BRANCH
  - 001000 / 001100 / 001101 → IEXEC
  - anything else → FETCH, with illegal_op=1 this cycle
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=010. lw → MEMRD; sw → MEMWR.
- MEMRD: MemRead=1, IorD=1. Holds until mem_ready=1, then → MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 → FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds until mem_ready=1, then → FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=100 → RWB.
- RWB: RegDst=1, MemtoReg=0, RegWrite=1 → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=011, PCWriteCond=1, PCSource=01 → FETCH.
- IEXEC:
  - ALUSrcA=1, ALUSrcB=10.
  - ALUOp: 010 for addi, 000 for andi, 001 for ori.
  - ZeroExt=1 for andi/ori, 0 for addi.
  - → IWB.
- IWB: RegDst=0, MemtoReg=0, RegWrite=1 → FETCH.
- instr_count:
  - Increments by 1 on each transition into FETCH from MEMWB, MEMWR (with mem_ready), RWB, BRANCH, IWB or JUMP.
  - Illegal opcodes are not counted.
  - Wraps modulo 2^CNT_W.
- Latencies, counted with mem_ready=1 every cycle:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type: 4 cycles
  - addi/andi/ori: 4 cycles
  - beq: 3 cycles
  - j: 3 cycles
- rst asserted in any state, including mid-wait: the pending memory strobe drops the same cycle. No RegWrite/PCWrite is issued.

Optional Feature:
- Macro: MC_JUMP_EN.
- Defined: opcode 000010 in DECODE → JUMP. JUMP drives PCWrite=1, PCSource=10, then → FETCH; counted as retired.
- Undefined: opcode 000010 is illegal (illegal_op pulse, → FETCH). State 9 is unreachable and decodes as an unused encoding.

Test Plan:
- rst=1 for 2 cycles, then release with mem_ready=1 → outputs all 0 during reset. First cycle after release: state=0, MemRead=1, IRWrite=1, PCWrite=1, ALUOp=010.
- Opcode=000000, mem_ready=1 → state sequence 0,1,6,7,0. ALUOp=100 in EXEC. RegWrite=1, RegDst=1 in RWB. instr_count +1.
- Opcode=100011 with mem_ready=0 for 3 cycles in MEMRD → state holds 3 for 3 cycles, MemRead=1, IorD=1. Then MEMWB has RegWrite=1, MemtoReg=1. Total 8 cycles.
- Opcode=001101 → IEXEC drives ALUOp=001, ZeroExt=1, ALUSrcB=10. IWB drives RegWrite=1, RegDst=0.
- Opcode=000100 → BRANCH drives ALUOp=011, PCWriteCond=1, PCSource=01. Opcode=111111 → illegal_op=1 in DECODE, back to FETCH, instr_count unchanged.
- Preload instr_count to all-ones via 2^CNT_W−1 retirements (CNT_W=4 build: 15 R-types), then one more → instr_count=0. Also assert rst during MEMWR wait → MemWrite=0 the same cycle and state=0 next cycle.
